// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial adder sequencer.
package serial_pkg;

   // Sequencer states. IDLE and DONE are exclusive, so a new operand
   // handshake never overlaps an unconsumed result.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_ADDER_LAT = 1;

   // Bits needed for a counter that reaches width+lat without wrapping.
   function automatic int cnt_bits(input int width, input int lat);
      return $clog2(width + lat + 1);
   endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out register: parallel load, right shift with zero
// fill, bit 0 presented as the serial output.
module piso_shift #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_lsb
);

   logic [WIDTH-1:0] r_data;

   // Load takes priority over shift; shifting moves toward bit 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_data;
      end else if (i_shift) begin
         r_data <= {1'b0, r_data[WIDTH-1:1]};
      end
   end

   assign o_lsb = r_data[0];

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer that wraps an external bit-serial adder as a parallel-operand
// valid/ready add unit. Operands go out LSB first plus one zero bit that
// yields the carry-out; the serial sum is collected into a WIDTH+1 result.
module serial_add_ctrl
   import serial_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int ADDER_LAT = DEF_ADDER_LAT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_sum,
   output logic             busy,
   output logic             adder_rst,
   output logic             adder_in1,
   output logic             adder_in2,
   input  logic             adder_sum
);

   localparam int CNT_W = cnt_bits(WIDTH, ADDER_LAT);
   localparam int LAST  = WIDTH + ADDER_LAT;

   state_t             r_state;
   state_t             w_next_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH:0]     r_res;
   logic               r_in_ready;
   logic               r_adder_rst;

   logic               w_handshake;
   logic               w_drive;
   logic               w_capture;
   logic               w_last;
   logic               w_sa_lsb;
   logic               w_sb_lsb;

   // in_ready is only ever high in IDLE, so it fully qualifies the handshake.
   assign w_handshake = in_valid && r_in_ready;
   // Operand bits (and the final zero-extension bit) go out for cnt 0..WIDTH.
   assign w_drive     = (r_state == RUN) && (int'(r_cnt) <= WIDTH);
   // The sum bit for cnt=k arrives ADDER_LAT cycles later.
   assign w_capture   = (r_state == RUN) && (int'(r_cnt) >= ADDER_LAT);
   assign w_last      = (r_state == RUN) && (int'(r_cnt) == LAST);

   piso_shift #(.WIDTH(WIDTH)) u_sa (
      .clk     (clk),
      .rst_n   (rst),
      .i_load  (w_handshake),
      .i_shift (w_drive),
      .i_data  (in_a),
      .o_lsb   (w_sa_lsb)
   );

   piso_shift #(.WIDTH(WIDTH)) u_sb (
      .clk     (clk),
      .rst_n   (rst),
      .i_load  (w_handshake),
      .i_shift (w_drive),
      .i_data  (in_b),
      .o_lsb   (w_sb_lsb)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of process ordering.
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode.
   always_comb begin
      // NOTE: default first so no path leaves the signal unassigned, which
      // would otherwise infer a latch.
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_handshake) w_next_state = CLEAR;
         CLEAR:   w_next_state = RUN;
         RUN:     if (w_last) w_next_state = DONE;
         DONE:    if (out_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Outputs decoded from state and registered datapath only.
   always_comb begin
      out_valid = 1'b0;
      busy      = 1'b0;
      adder_in1 = 1'b0;
      adder_in2 = 1'b0;
      case (r_state)
         IDLE:    busy = 1'b0;
         CLEAR:   busy = 1'b1;
         RUN: begin
            busy      = 1'b1;
            adder_in1 = w_drive && w_sa_lsb;
            adder_in2 = w_drive && w_sb_lsb;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

   // Registered handshake and carry-clear strobes; carry clear is held
   // asserted throughout reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_in_ready  <= 1'b0;
         r_adder_rst <= 1'b1;
      end else begin
         r_in_ready  <= (w_next_state == IDLE);
         r_adder_rst <= (w_next_state == CLEAR);
      end
   end

   // Bit counter and LSB-first result collection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
         r_res <= '0;
      end else begin
         if (r_state == CLEAR) begin
            r_cnt <= '0;
         end else if ((r_state == RUN) && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_capture) begin
            r_res <= {adder_sum, r_res[WIDTH:1]};
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign adder_rst = r_adder_rst;
   assign out_sum   = r_res;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl. Three instances share clk/rst and
// differ only in ADDER_LAT (0, 1, 2); each drives its own behavioural
// serial adder. Instance index equals ADDER_LAT.
module tb_serial_add_ctrl;

   localparam int W   = 8;
   localparam int TMO = 100;

   logic             clk;
   logic             rst;
   logic [2:0]       in_valid;
   logic [2:0]       out_ready;
   logic [W-1:0]     in_a [3];
   logic [W-1:0]     in_b [3];
   wire  [2:0]       in_ready;
   wire  [2:0]       out_valid;
   wire  [2:0]       busy;
   wire  [2:0]       adder_rst;
   wire  [2:0]       adder_in1;
   wire  [2:0]       adder_in2;
   wire  [2:0]       adder_sum;
   wire  [W:0]       out_sum [3];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_inst
      logic carry, d1, d2;
      wire  comb_sum = adder_in1[g] ^ adder_in2[g] ^ carry;

      // Serial adder model: synchronous active-high clear, registered carry,
      // sum delayed by g cycles.
      always @(posedge clk) begin
         if (adder_rst[g]) begin
            carry <= 1'b0;
            d1    <= 1'b0;
            d2    <= 1'b0;
         end else begin
            carry <= (adder_in1[g] & adder_in2[g]) | (carry & (adder_in1[g] ^ adder_in2[g]));
            d1    <= comb_sum;
            d2    <= d1;
         end
      end

      assign adder_sum[g] = (g == 0) ? comb_sum : ((g == 1) ? d1 : d2);

      serial_add_ctrl #(.WIDTH(W), .ADDER_LAT(g)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_a      (in_a[g]),
         .in_b      (in_b[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_sum   (out_sum[g]),
         .busy      (busy[g]),
         .adder_rst (adder_rst[g]),
         .adder_in1 (adder_in1[g]),
         .adder_in2 (adder_in2[g]),
         .adder_sum (adder_sum[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One operation on instance k, called at a falling edge. Latency is the
   // number of rising edges from the handshake edge through the edge that
   // raised out_valid, both inclusive. Returns at the falling edge where
   // out_valid is first seen; the caller owns out_ready.
   task automatic run_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W:0] exp, input string tag);
      int w;
      int lat;
      int rc;
      in_a[k] = a;
      in_b[k] = b;
      in_valid[k] = 1'b1;
      w = 0;
      while (in_ready[k] !== 1'b1 && w < TMO) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_accept"}, 32'(w < TMO), 32'd1);
      @(negedge clk);
      // Changing data after the handshake must be ignored.
      in_valid[k] = 1'b0;
      in_a[k] = ~a;
      in_b[k] = a ^ b;
      lat = 1;
      rc  = 0;
      while (out_valid[k] !== 1'b1 && lat < TMO) begin
         if (adder_rst[k] === 1'b1) rc++;
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(W + k + 3));
      check({tag, "_sum"}, 32'(out_sum[k]), 32'(exp));
      check({tag, "_clr"}, 32'(rc), 32'd1);
   endtask

   initial begin
      int w, hs1, hs2, nv;
      logic [W-1:0] ra, rb;

      rst       = 1'b0;
      in_valid  = '0;
      out_ready = '1;
      for (int i = 0; i < 3; i++) begin
         in_a[i] = '0;
         in_b[i] = '0;
      end

      // Reset values.
      repeat (3) @(negedge clk);
      check("rst_in_ready",  32'(in_ready[1]),  32'd0);
      check("rst_out_valid", 32'(out_valid[1]), 32'd0);
      check("rst_out_sum",   32'(out_sum[1]),   32'd0);
      check("rst_busy",      32'(busy[1]),      32'd0);
      check("rst_adder_rst", 32'(adder_rst[1]), 32'd1);
      check("rst_adder_in",  32'({adder_in1[1], adder_in2[1]}), 32'd0);
      rst = 1'b1;
      #1;
      check("rel_in_ready_0", 32'(in_ready[1]), 32'd0);
      @(negedge clk);
      check("rel_in_ready_1", 32'(in_ready[1]), 32'd1);
      check("rel_adder_rst",  32'(adder_rst[1]), 32'd0);

      // Basic add and carry-out cases.
      run_op(1, 8'h0D, 8'h0E, 9'h01B, "basic");
      run_op(1, 8'hFF, 8'h01, 9'h100, "ff_01");
      run_op(1, 8'hFF, 8'hFF, 9'h1FE, "ff_ff");
      run_op(1, 8'h00, 8'h00, 9'h000, "zero");

      // Backpressure: result held while out_ready is low.
      @(negedge clk);
      out_ready[1] = 1'b0;
      run_op(1, 8'h3C, 8'hC3, 9'h0FF, "bp");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid",    32'(out_valid[1]), 32'd1);
         check("bp_sum",      32'(out_sum[1]),   32'h0FF);
         check("bp_in_ready", 32'(in_ready[1]),  32'd0);
         check("bp_busy",     32'(busy[1]),      32'd1);
      end
      out_ready[1] = 1'b1;
      @(negedge clk);
      check("bp_rel_busy",     32'(busy[1]),      32'd0);
      check("bp_rel_valid",    32'(out_valid[1]), 32'd0);
      check("bp_rel_in_ready", 32'(in_ready[1]),  32'd1);

      // Back-to-back with in_valid held high throughout.
      in_a[1] = 8'h12;
      in_b[1] = 8'h34;
      in_valid[1] = 1'b1;
      w = 0;
      while (in_ready[1] !== 1'b1 && w < TMO) begin @(negedge clk); w++; end
      hs1 = cyc;
      @(negedge clk);
      in_a[1] = 8'h80;
      in_b[1] = 8'h80;
      w = 0;
      while (out_valid[1] !== 1'b1 && w < TMO) begin @(negedge clk); w++; end
      check("b2b_sum1", 32'(out_sum[1]), 32'h046);
      w = 0;
      while (in_ready[1] !== 1'b1 && w < TMO) begin @(negedge clk); w++; end
      hs2 = cyc;
      check("b2b_spacing", 32'(hs2 - hs1), 32'd13);
      @(negedge clk);
      in_valid[1] = 1'b0;
      in_a[1] = 8'hAA;
      w = 0;
      while (out_valid[1] !== 1'b1 && w < TMO) begin @(negedge clk); w++; end
      check("b2b_sum2", 32'(out_sum[1]), 32'h100);
      @(negedge clk);

      // Reset in the middle of RUN (cnt=4).
      in_a[1] = 8'hFF;
      in_b[1] = 8'hFF;
      in_valid[1] = 1'b1;
      w = 0;
      while (in_ready[1] !== 1'b1 && w < TMO) begin @(negedge clk); w++; end
      @(negedge clk);
      in_valid[1] = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_busy_pre", 32'(busy[1]), 32'd1);
      rst = 1'b0;
      #1;
      check("mid_adder_rst", 32'(adder_rst[1]), 32'd1);
      check("mid_busy",      32'(busy[1]),      32'd0);
      check("mid_out_valid", 32'(out_valid[1]), 32'd0);
      check("mid_out_sum",   32'(out_sum[1]),   32'd0);
      check("mid_in_ready",  32'(in_ready[1]),  32'd0);
      check("mid_adder_in",  32'({adder_in1[1], adder_in2[1]}), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      nv = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid[1] === 1'b1) nv++;
      end
      check("mid_no_valid", 32'(nv), 32'd0);
      run_op(1, 8'h01, 8'h01, 9'h002, "post_rst");

      // Random sweeps on the ADDER_LAT=0 and ADDER_LAT=2 instances.
      for (int k = 0; k < 3; k += 2) begin
         for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(k, ra, rb, {1'b0, ra} + {1'b0, rb}, (k == 0) ? "sweep_lat0" : "sweep_lat2");
         end
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer that owns one bit-serial adder (ports clk, rst, in1, in2, sum) and presents it as a parallel-operand, valid/ready add unit.
- Accepts two WIDTH-bit operands, clears the adder's carry, streams the operands LSB-first plus one zero-extension bit, collects the serial sum, and returns a WIDTH+1-bit result.
- Sits between upstream parallel logic and the serial adder instance; the adder is instantiated outside this block and wired to the adder_* ports.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- ADDER_LAT, 1, cycles from in1/in2 applied to the matching sum bit on adder_sum (legal 0..2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  WIDTH+1  result A+B; bit WIDTH is carry-out.
- busy  out  1  high in any state other than IDLE.
- adder_rst  out  1  active-high carry clear to the adder's rst.
- adder_in1  out  1  serial bit to the adder's in1.
- adder_in2  out  1  serial bit to the adder's in2.
- adder_sum  in  1  serial sum from the adder's sum.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; counters and shift registers go to 0.
  - out_valid=0, out_sum=0, adder_in1=0, adder_in2=0, busy=0.
  - adder_rst=1 while rst is low, so the carry is held clear.
  - in_ready=1 one cycle after rst deasserts.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - in_ready=1; adder_rst=0.
  - On in_valid&in_ready: latch in_a and in_b into shift registers sa and sb, go to CLEAR.
- CLEAR:
  - One cycle; in_ready=0, adder_rst=1, adder_in1=adder_in2=0.
  - Counter cnt is set to 0; go to RUN.
- RUN (cnt runs 0..WIDTH+ADDER_LAT):
  - While cnt<=WIDTH, drive adder_in1=sa[0] and adder_in2=sb[0], then shift sa and sb right with zero fill. Cycle cnt=WIDTH therefore drives 0/0, which produces the carry-out bit.
  - When cnt>WIDTH, drive adder_in1=adder_in2=0.
  - When cnt>=ADDER_LAT, capture adder_sum into the result register: res <= {adder_sum, res[WIDTH:1]}. This makes exactly WIDTH+1 captures, LSB first.
  - At cnt=WIDTH+ADDER_LAT, go to DONE.
- DONE:
  - out_valid=1; out_sum=res, held stable while out_valid&!out_ready.
  - On out_ready, go to IDLE; out_valid drops next cycle.
  - in_ready=0 throughout DONE, so a new operation never overlaps an unconsumed result.
- Latency: out_valid rises WIDTH+ADDER_LAT+3 cycles after the input handshake edge (12 for defaults).
- Throughput: at most one operation per WIDTH+ADDER_LAT+4 cycles with out_ready held high.
- Width and arithmetic: the result is unsigned, (WIDTH+1) bits, never truncated. cnt is $clog2(WIDTH+ADDER_LAT+1) bits and never wraps.
- Boundary conditions:
  - in_valid with changing data while not in IDLE is ignored; only the data present at the handshake is used.
  - rst asserted mid-RUN aborts the operation: no out_valid is produced and the adder is cleared.
  - out_ready high in a non-DONE state has no effect.
  - A handshake in the same cycle as an out_ready release is not possible, because IDLE and DONE are exclusive.

Decomposition:
- Shared package serial_pkg holds:
  - the state enumeration (IDLE=2'd0, CLEAR=2'd1, RUN=2'd2, DONE=2'd3);
  - the default WIDTH and ADDER_LAT constants.
- One natural sub-module: piso_shift (parallel-in serial-out register, load/shift enables, zero fill), instantiated twice for sa and sb.
- Result capture and FSM stay in the top level.

Test Plan:
- Basic add, WIDTH=8, ADDER_LAT=1, paired with a behavioural serial adder model:
  - in_a=0x0D, in_b=0x0E -> out_sum=0x01B.
  - out_valid first seen 12 cycles after the handshake.
  - adder_rst high for exactly 1 cycle.
- Carry-out cases:
  - 0xFF+0x01 -> 0x100.
  - 0xFF+0xFF -> 0x1FE.
  - 0x00+0x00 -> 0x000.
- Backpressure: hold out_ready=0 for 5 cycles -> out_valid and out_sum stable, in_ready=0, busy=1; release -> IDLE next cycle, in_ready=1.
- Back-to-back: continuous in_valid with out_ready=1 over 0x12+0x34 and 0x80+0x80 -> results 0x046 and 0x100, in order; the second handshake occurs exactly 13 cycles after the first.
- Reset mid-op: assert rst at RUN cnt=4 -> outputs go immediately to their reset values (adder_rst=1); no out_valid; the next add, 0x01+0x01, gives 0x002, proving the carry was cleared.
- ADDER_LAT=0 and ADDER_LAT=2 builds: random 200-pair sweep vs. a reference sum -> all match; latency equals WIDTH+ADDER_LAT+3.
